lcd_sequencer: RTL and testbench
================================

# lcd_sequencer

Sequencer and arbiter for the 4-bit HD44780-style LCD port (`dataout[3:0]`, `control[2:0]`).
- After reset it runs the power-on initialisation sequence autonomously.
- It then shares the port between two byte requesters (e.g. opcode display and status line) using round-robin arbitration.
- Each accepted byte is split into two nibble strobes, followed by the command's execution wait.
- It sits between the display clients and the LCD pins, on the system `clk`.

## Interface
- `E_SETUP`, 2: cycles data/RS are stable before E rises (≥1).
- `E_PULSE`, 12: cycles E is high (≥1).
- `NIBBLE_GAP`, 50: cycles data is held after E falls (≥1).
- `CMD_WAIT`, 2000: post-byte wait for ordinary commands/data.
- `CLR_WAIT`, 82000: post-byte wait for clear/home (RS=0, data 0x01–0x03).
- `INIT_WAIT`, 205000: wait after the first two init nibbles.
- `PWR_WAIT`, 750000: power-up wait before the first init nibble.
- All waits are in the range 1 to 2^20−1; a single 20-bit down-counter serves all of them.
- `clk` in 1: system clock; everything is on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `req0_valid`, `req1_valid` in 1: requester has a byte pending.
- `req0_rs`, `req1_rs` in 1: 0 = command, 1 = data.
- `req0_data`, `req1_data` in 8: byte to write.
- `req0_ready`, `req1_ready` out 1: byte accepted this cycle when valid & ready.
- `dataout` out 4: LCD D7..D4.
- `control` out 3: bit 2 = RS, bit 1 = RW (always 0), bit 0 = E.
- `init_done` out 1: high once initialisation completes; stays high until reset.

## Operation
- States:
  - PWR: PWR_WAIT cycles.
  - INIT: the init script.
  - IDLE.
  - SETUP: E_SETUP cycles.
  - STROBE: E_PULSE cycles.
  - HOLD: NIBBLE_GAP cycles.
  - POST: byte wait.
- Init script, all RS=0:
  - Single nibbles, each followed by its wait: 0x3 (INIT_WAIT), 0x3 (INIT_WAIT), 0x3 (CMD_WAIT), 0x2 (CMD_WAIT).
  - Full bytes: 0x28, 0x0C, 0x06, 0x01. The last one uses CLR_WAIT.
  - `init_done` rises on the cycle after the final wait ends; the block enters IDLE on that same cycle.
- Every nibble follows SETUP → STROBE → HOLD.
- A byte is sent as its high nibble, then its low nibble, then POST.
  - POST lasts CLR_WAIT if RS=0 and data ∈ {0x01, 0x02, 0x03}; otherwise it lasts CMD_WAIT.
- Arbitration happens in IDLE only:
  - Only one requester valid: it is granted.
  - Both valid: grant goes to the requester not served last. The `last` register resets to 1, so req0 wins first.
  - `reqN_ready` is combinational: `(state==IDLE) & init_done & grantN`. It is never high for both at once.
  - On acceptance, RS and data are latched internally. The requester may change its inputs on the next cycle.
  - `last` updates only on acceptance.
- Requests arriving during init or a busy byte are not lost. Valid stays high until ready; no timeout is applied.
- Reset values: `dataout`=0, `control`=0, both readys 0, `init_done`=0, `last`=1, state PWR, counter loaded with PWR_WAIT.
- Reset mid-operation: on the next cycle E=0 and all outputs take their reset values. The full init sequence then restarts. A partial byte is dropped.

## Timing
- `dataout` and `control` are registered. `ready` is combinational from registered state.
- Acceptance at cycle t:
  - From t+1: high nibble and RS driven, E=0.
  - E=1 for cycles [t+1+E_SETUP, t+E_SETUP+E_PULSE].
  - Data is held through NIBBLE_GAP.
  - The low nibble starts at t+1+E_SETUP+E_PULSE+NIBBLE_GAP, with the same phasing.
- IDLE (next possible acceptance) is reached at t+1+2·(E_SETUP+E_PULSE+NIBBLE_GAP)+wait.
- During POST and IDLE: E=0; RS and `dataout` hold their last driven values.
- Back-to-back transfers: IDLE lasts one cycle when a request is pending, so there are no extra bubbles.
- First init E rise after reset release (rst_n high at cycle 0): cycle PWR_WAIT+E_SETUP.

## Test plan
All scenarios use E_SETUP=1, E_PULSE=2, NIBBLE_GAP=1, CMD_WAIT=4, CLR_WAIT=8, INIT_WAIT=6, PWR_WAIT=10.
1. Reset: rst_n low for 5 cycles with both valid high → `dataout`=0, `control`=0, readys 0, `init_done`=0. First E rise occurs 11 cycles after release, with `dataout`=0x3 and RS=0.
2. Init: observe E rising edges → exactly 12 pulses with nibbles 3,3,3,2,2,8,0,C,0,6,0,1, all RS=0. `init_done`=1 after the final 8-cycle wait, with no E activity between.
3. Single data write: req0 valid, rs=1, data=0x41 → nibbles 0x4 then 0x1 with `control[2]`=1 and `control[1]`=0. `req0_ready` returns 13 cycles after acceptance.
4. Contention: both requesters continuously valid (req0=0x30, req1=0x31, rs=1) → grants alternate 0,1,0,1 starting with req0. Accepts are spaced 13 cycles apart.
5. Clear command: req1 rs=0, data=0x01 → POST lasts 8 cycles, next accept at t+17. With rs=1, data=0x01 → next accept at t+13.
6. Mid-byte reset: assert rst_n low while E=1 → `control`=0 on the next cycle. After release, the init sequence is repeated exactly as in scenario 2, and the interrupted byte is never completed.

Source files
------------

// File: rtl/lcd_sequencer_if.sv
// Bundle between the display clients and the LCD sequencer: two byte
// requesters (valid/ready with RS and data) plus the 4-bit LCD pin outputs.
// master = client/pin side, slave = the sequencer.
interface lcd_sequencer_if;
  logic       req0_valid;
  logic       req0_rs;
  logic [7:0] req0_data;
  logic       req0_ready;
  logic       req1_valid;
  logic       req1_rs;
  logic [7:0] req1_data;
  logic       req1_ready;
  logic [3:0] dataout;
  logic [2:0] control;
  logic       init_done;

  modport master (
    output req0_valid, req0_rs, req0_data,
    output req1_valid, req1_rs, req1_data,
    input  req0_ready, req1_ready,
    input  dataout, control, init_done
  );

  modport slave (
    input  req0_valid, req0_rs, req0_data,
    input  req1_valid, req1_rs, req1_data,
    output req0_ready, req1_ready,
    output dataout, control, init_done
  );
endinterface

// File: rtl/lcd_sequencer.sv
// HD44780 4-bit port sequencer: power-on init script, then round-robin
// sharing of the port between two byte requesters.
// Ports: clk, rst_n (sync, active low), bus (lcd_sequencer_if.slave):
//   req0/req1 valid/rs/data in, ready out; dataout = D7..D4,
//   control = {RS, RW(0), E}; init_done high after the init script.
module lcd_sequencer #(
  parameter int unsigned E_SETUP    = 2,
  parameter int unsigned E_PULSE    = 12,
  parameter int unsigned NIBBLE_GAP = 50,
  parameter int unsigned CMD_WAIT   = 2000,
  parameter int unsigned CLR_WAIT   = 82000,
  parameter int unsigned INIT_WAIT  = 205000,
  parameter int unsigned PWR_WAIT   = 750000
) (
  input logic            clk,
  input logic            rst_n,
  lcd_sequencer_if.slave bus
);

  typedef enum logic [2:0] {PWR, INIT, IDLE, SETUP, STROBE, HOLD, POST} state_t;

  localparam logic [19:0] T_SETUP = 20'(E_SETUP);
  localparam logic [19:0] T_PULSE = 20'(E_PULSE);
  localparam logic [19:0] T_GAP   = 20'(NIBBLE_GAP);
  localparam logic [19:0] T_CMD   = 20'(CMD_WAIT);
  localparam logic [19:0] T_CLR   = 20'(CLR_WAIT);
  localparam logic [19:0] T_INIT  = 20'(INIT_WAIT);
  localparam logic [19:0] T_PWR   = 20'(PWR_WAIT);
  localparam logic [7:0]  FIRST_BYTE = 8'h30;

  state_t      state, state_nx;
  logic [19:0] cnt, cnt_nx;
  logic [2:0]  step, step_nx;
  logic        lo, lo_nx;
  logic        single, single_nx;
  logic        cur_rs, cur_rs_nx;
  logic [7:0]  cur_byte, cur_byte_nx;
  logic        done, done_nx;
  logic        last, last_nx;
  logic [3:0]  dout, dout_nx;
  logic        rs_o, rs_o_nx;
  logic        e_o, e_o_nx;

  logic        grant0, grant1, rdy0, rdy1, cnt_end, is_clr;
  logic [19:0] byte_wait;
  logic [7:0]  next_step_byte, sel_byte;
  logic        sel_rs;

  // Init script: steps 0-3 are single high nibbles, 4-7 full bytes.
  function automatic logic [7:0] script_byte(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd1, 3'd2: script_byte = 8'h30;
      3'd3:             script_byte = 8'h20;
      3'd4:             script_byte = 8'h28;
      3'd5:             script_byte = 8'h0C;
      3'd6:             script_byte = 8'h06;
      default:          script_byte = 8'h01;
    endcase
  endfunction

  // last = index of the requester served most recently.
  assign grant0 = bus.req0_valid & (~bus.req1_valid | last);
  assign grant1 = bus.req1_valid & (~bus.req0_valid | ~last);
  assign rdy0   = (state == IDLE) & done & grant0;
  assign rdy1   = (state == IDLE) & done & grant1;

  assign bus.req0_ready = rdy0;
  assign bus.req1_ready = rdy1;
  assign bus.dataout    = dout;
  assign bus.control    = {rs_o, 1'b0, e_o};
  assign bus.init_done  = done;

  assign cnt_end        = (cnt == 20'd1);
  assign is_clr         = ~cur_rs & (cur_byte[7:2] == 6'd0) & (cur_byte[1:0] != 2'd0);
  // The first two init nibbles get the long wait; everything else uses the byte rule.
  assign byte_wait      = (~done & (step < 3'd2)) ? T_INIT : (is_clr ? T_CLR : T_CMD);
  assign next_step_byte = script_byte(step + 3'd1);
  assign sel_byte       = rdy0 ? bus.req0_data : bus.req1_data;
  assign sel_rs         = rdy0 ? bus.req0_rs : bus.req1_rs;

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    step_nx     = step;
    lo_nx       = lo;
    single_nx   = single;
    cur_rs_nx   = cur_rs;
    cur_byte_nx = cur_byte;
    done_nx     = done;
    last_nx     = last;
    dout_nx     = dout;
    rs_o_nx     = rs_o;
    e_o_nx      = 1'b0;

    case (state)
      PWR: begin
        if (cnt_end) begin
          state_nx    = SETUP;
          cnt_nx      = T_SETUP;
          cur_byte_nx = FIRST_BYTE;
          cur_rs_nx   = 1'b0;
          single_nx   = 1'b1;
          lo_nx       = 1'b0;
          dout_nx     = FIRST_BYTE[7:4];
          rs_o_nx     = 1'b0;
        end else begin
          cnt_nx = cnt - 20'd1;
        end
      end
      INIT: begin
        if (cnt_end) begin
          if (step == 3'd7) begin
            state_nx = IDLE;
            done_nx  = 1'b1;
          end else begin
            state_nx    = SETUP;
            cnt_nx      = T_SETUP;
            step_nx     = step + 3'd1;
            cur_byte_nx = next_step_byte;
            cur_rs_nx   = 1'b0;
            single_nx   = (step < 3'd3);
            lo_nx       = 1'b0;
            dout_nx     = next_step_byte[7:4];
            rs_o_nx     = 1'b0;
          end
        end else begin
          cnt_nx = cnt - 20'd1;
        end
      end
      IDLE: begin
        if (rdy0 | rdy1) begin
          state_nx    = SETUP;
          cnt_nx      = T_SETUP;
          cur_byte_nx = sel_byte;
          cur_rs_nx   = sel_rs;
          single_nx   = 1'b0;
          lo_nx       = 1'b0;
          last_nx     = rdy1;
          dout_nx     = sel_byte[7:4];
          rs_o_nx     = sel_rs;
        end
      end
      SETUP: begin
        if (cnt_end) begin
          state_nx = STROBE;
          cnt_nx   = T_PULSE;
          e_o_nx   = 1'b1;
        end else begin
          cnt_nx = cnt - 20'd1;
        end
      end
      STROBE: begin
        if (cnt_end) begin
          state_nx = HOLD;
          cnt_nx   = T_GAP;
        end else begin
          cnt_nx = cnt - 20'd1;
          e_o_nx = 1'b1;
        end
      end
      HOLD: begin
        if (cnt_end) begin
          if (~lo & ~single) begin
            state_nx = SETUP;
            cnt_nx   = T_SETUP;
            lo_nx    = 1'b1;
            dout_nx  = cur_byte[3:0];
          end else begin
            state_nx = done ? POST : INIT;
            cnt_nx   = byte_wait;
          end
        end else begin
          cnt_nx = cnt - 20'd1;
        end
      end
      POST: begin
        if (cnt_end) state_nx = IDLE;
        else         cnt_nx   = cnt - 20'd1;
      end
      default: state_nx = PWR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= PWR;
      cnt      <= T_PWR;
      step     <= 3'd0;
      lo       <= 1'b0;
      single   <= 1'b1;
      cur_rs   <= 1'b0;
      cur_byte <= 8'h00;
      done     <= 1'b0;
      last     <= 1'b1;
      dout     <= 4'h0;
      rs_o     <= 1'b0;
      e_o      <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      step     <= step_nx;
      lo       <= lo_nx;
      single   <= single_nx;
      cur_rs   <= cur_rs_nx;
      cur_byte <= cur_byte_nx;
      done     <= done_nx;
      last     <= last_nx;
      dout     <= dout_nx;
      rs_o     <= rs_o_nx;
      e_o      <= e_o_nx;
    end
  end

endmodule

// File: tb/tb_lcd_sequencer.sv
// Self-checking bench for lcd_sequencer: directed scenarios plus a random
// phase, all checked against a timeline model of E pulses and grants.
module tb_lcd_sequencer;
  localparam int ES  = 1;
  localparam int EP  = 2;
  localparam int NG  = 1;
  localparam int CW  = 4;
  localparam int CLW = 8;
  localparam int IW  = 6;
  localparam int PW  = 10;
  localparam int P   = ES + EP + NG;

  typedef struct {
    int         t;
    logic [3:0] nib;
    logic       rs;
  } pulse_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst_q = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;

  lcd_sequencer_if bus();

  lcd_sequencer #(
    .E_SETUP(ES), .E_PULSE(EP), .NIBBLE_GAP(NG), .CMD_WAIT(CW),
    .CLR_WAIT(CLW), .INIT_WAIT(IW), .PWR_WAIT(PW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst_n;
  end

  int n_pass = 0;
  int n_tot  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot = n_tot + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // ---------------- reference model ----------------
  pulse_t     exp_q[$];
  int         m_idle_at = 0;
  int         m_done_at = 0;
  logic       m_last = 1'b1;
  logic       m_active = 1'b0;
  int         pulses_since_rst = 0;
  int         acc_who[$];
  int         acc_cyc[$];
  logic [3:0] obs_nib[$];
  logic       obs_rs[$];
  logic       acc0 = 1'b0;
  logic       acc1 = 1'b0;

  function automatic int model_wait(input logic rs, input logic [7:0] d);
    return (!rs && d >= 8'd1 && d <= 8'd3) ? CLW : CW;
  endfunction

  task automatic push_pulse(input int t, input logic [3:0] nib, input logic rs);
    pulse_t p;
    p.t = t; p.nib = nib; p.rs = rs;
    exp_q.push_back(p);
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_active = 1'b0;
  endtask

  // Expected init timeline relative to the first cycle out of reset.
  task automatic model_init(input int rel);
    logic [7:0] script [8];
    int         nib_wait [4];
    int         s;
    script   = '{8'h30, 8'h30, 8'h30, 8'h20, 8'h28, 8'h0C, 8'h06, 8'h01};
    nib_wait = '{IW, IW, CW, CW};
    s = rel + PW;
    for (int i = 0; i < 8; i++) begin
      if (i < 4) begin
        push_pulse(s + ES, script[i][7:4], 1'b0);
        s = s + P + nib_wait[i];
      end else begin
        push_pulse(s + ES, script[i][7:4], 1'b0);
        push_pulse(s + P + ES, script[i][3:0], 1'b0);
        s = s + 2 * P + model_wait(1'b0, script[i]);
      end
    end
    m_done_at = s;
    m_idle_at = s;
    m_last = 1'b1;
    pulses_since_rst = 0;
    m_active = 1'b1;
  endtask

  // ---------------- monitor / checker ----------------
  logic       prev_e = 1'b0;
  int         elen = 0;
  logic       g0, g1, r0, r1, idle_m, e_now;
  logic [7:0] a_d;
  logic       a_rs;
  pulse_t     pp;

  always @(negedge clk) begin
    if (!rst_q) begin
      check("rst_control", 32'(bus.control), 0);
      check("rst_dataout", 32'(bus.dataout), 0);
      check("rst_ready0", 32'(bus.req0_ready), 0);
      check("rst_ready1", 32'(bus.req1_ready), 0);
      check("rst_init_done", 32'(bus.init_done), 0);
      prev_e = 1'b0;
      elen = 0;
    end else if (m_active) begin
      check("init_done", 32'(bus.init_done), 32'(cyc >= m_done_at));
      idle_m = (cyc >= m_idle_at);
      g0 = bus.req0_valid & (!bus.req1_valid | m_last);
      g1 = bus.req1_valid & (!bus.req0_valid | !m_last);
      r0 = idle_m & g0;
      r1 = idle_m & g1;
      check("ready0", 32'(bus.req0_ready), 32'(r0));
      check("ready1", 32'(bus.req1_ready), 32'(r1));
      if (r0 || r1) begin
        a_d  = r0 ? bus.req0_data : bus.req1_data;
        a_rs = r0 ? bus.req0_rs : bus.req1_rs;
        m_last = r1;
        push_pulse(cyc + 1 + ES, a_d[7:4], a_rs);
        push_pulse(cyc + 1 + ES + P, a_d[3:0], a_rs);
        m_idle_at = cyc + 1 + 2 * P + model_wait(a_rs, a_d);
        acc_who.push_back(r1 ? 1 : 0);
        acc_cyc.push_back(cyc);
        if (r1) acc1 = 1'b1;
        else    acc0 = 1'b1;
      end
      e_now = bus.control[0];
      if (e_now && !prev_e) begin
        pulses_since_rst++;
        obs_nib.push_back(bus.dataout);
        obs_rs.push_back(bus.control[2]);
        check("pulse_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          pp = exp_q.pop_front();
          check("pulse_time", cyc, pp.t);
          check("pulse_nibble", 32'(bus.dataout), 32'(pp.nib));
          check("pulse_rs", 32'(bus.control[2]), 32'(pp.rs));
          check("pulse_rw", 32'(bus.control[1]), 0);
        end
      end
      if (!e_now && prev_e) check("e_width", elen, EP);
      elen = e_now ? elen + 1 : 0;
      prev_e = e_now;
    end
  end

  // ---------------- stimulus ----------------
  int rel;

  task automatic wait_acc(input int n, input string tag);
    int b = 0;
    while (acc_who.size() < n && b < 300) begin
      @(posedge clk); #1;
      b++;
    end
    check(tag, 32'(acc_who.size() >= n), 1);
  endtask

  task automatic wait_init(input string tag);
    int b = 0;
    while (!bus.init_done && b < 300) begin
      @(posedge clk); #1;
      b++;
    end
    check(tag, cyc - rel, 98);
  endtask

  initial begin
    int b;
    bus.req0_valid = 1'b1; bus.req0_rs = 1'b1; bus.req0_data = 8'h30;
    bus.req1_valid = 1'b1; bus.req1_rs = 1'b1; bus.req1_data = 8'h31;

    // Reset with both requesters valid.
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;
    rel = cyc;
    model_init(rel);

    // First init strobe.
    b = 0;
    while (!bus.control[0] && b < 100) begin
      @(posedge clk); #1;
      b++;
    end
    check("first_rise_cycle", cyc - rel, 11);
    check("first_rise_dataout", 32'(bus.dataout), 3);
    check("first_rise_rs", 32'(bus.control[2]), 0);

    // Init completes, 12 nibbles.
    wait_init("init_done_cycle");
    check("init_pulse_count", pulses_since_rst, 12);
    check("init_queue_drained", exp_q.size(), 0);

    // Contention: both valid, alternate starting with req0.
    wait_acc(4, "contention_timeout");
    bus.req1_valid = 1'b0;
    check("cont_first_cycle", acc_cyc[0] - rel, 98);
    for (int i = 0; i < 4; i++) begin
      check("cont_grant", acc_who[i], i % 2);
      if (i > 0) check("cont_spacing", acc_cyc[i] - acc_cyc[i-1], 13);
    end

    // Single data write 0x41 on req0, then next byte 13 cycles later.
    wait_acc(5, "single_pre_timeout");
    bus.req0_data = 8'h41;
    wait_acc(6, "single_timeout");
    bus.req0_data = 8'h42;
    wait_acc(7, "single_next_timeout");
    bus.req0_valid = 1'b0;
    check("single_ready_return", acc_cyc[6] - acc_cyc[5], 13);
    check("single_hi_nibble", 32'(obs_nib[22]), 4);
    check("single_lo_nibble", 32'(obs_nib[23]), 1);
    check("single_hi_rs", 32'(obs_rs[22]), 1);
    check("single_lo_rs", 32'(obs_rs[23]), 1);

    // Clear command vs data 0x01.
    bus.req1_valid = 1'b1; bus.req1_rs = 1'b0; bus.req1_data = 8'h01;
    wait_acc(8, "clr_timeout");
    bus.req1_rs = 1'b1; bus.req1_data = 8'h01;
    wait_acc(9, "clr_next_timeout");
    bus.req1_data = 8'h55;
    wait_acc(10, "data01_next_timeout");
    bus.req1_valid = 1'b0;
    check("clr_grant", acc_who[7], 1);
    check("clr_spacing", acc_cyc[8] - acc_cyc[7], 17);
    check("data01_spacing", acc_cyc[9] - acc_cyc[8], 13);

    // Random traffic.
    acc0 = 1'b0; acc1 = 1'b0;
    for (int k = 0; k < 600; k++) begin
      @(posedge clk); #1;
      if (!bus.req0_valid || acc0) begin
        acc0 = 1'b0;
        bus.req0_valid = ($urandom_range(0, 3) != 0);
        bus.req0_rs    = 1'($urandom_range(0, 1));
        bus.req0_data  = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
      end
      if (!bus.req1_valid || acc1) begin
        acc1 = 1'b0;
        bus.req1_valid = ($urandom_range(0, 3) != 0);
        bus.req1_rs    = 1'($urandom_range(0, 1));
        bus.req1_data  = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
      end
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    b = 0;
    while ((exp_q.size() != 0 || cyc < m_idle_at) && b < 100) begin
      @(posedge clk); #1;
      b++;
    end
    check("random_drained", exp_q.size(), 0);

    // Reset in the middle of a byte while E is high.
    bus.req0_valid = 1'b1; bus.req0_rs = 1'b1; bus.req0_data = 8'h5A;
    b = 0;
    while (!bus.control[0] && b < 100) begin
      @(posedge clk); #1;
      b++;
    end
    check("mid_e_seen", 32'(bus.control[0]), 1);
    rst_n = 1'b0;
    model_reset();
    bus.req0_valid = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_control", 32'(bus.control), 0);
    check("mid_rst_dataout", 32'(bus.dataout), 0);
    check("mid_rst_init_done", 32'(bus.init_done), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    rel = cyc;
    model_init(rel);
    wait_init("reinit_done_cycle");
    check("reinit_pulse_count", pulses_since_rst, 12);
    check("reinit_queue_drained", exp_q.size(), 0);
    repeat (30) @(posedge clk);
    #1;
    check("no_resumed_byte", pulses_since_rst, 12);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
